// File: rtl/cordic_vector_iter_if.sv
// Handshake and data bundle for the vectoring CORDIC engine.
// The master side presents (x, y) and consumes the result.
// The slave side is the engine itself.
interface cordic_vector_iter_if #(
    parameter int WIDTH = 32
) ();
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] x_in;
    logic signed [WIDTH-1:0] y_in;
    logic                    out_valid;
    logic                    out_ready;
    logic        [WIDTH+1:0] mag_out;
    logic signed [31:0]      angle_out;

    modport master (
        output in_valid, x_in, y_in, out_ready,
        input  in_ready, out_valid, mag_out, angle_out
    );

    modport slave (
        input  in_valid, x_in, y_in, out_ready,
        output in_ready, out_valid, mag_out, angle_out
    );
endinterface

// File: rtl/cordic_vector_iter.sv
// Iterative vectoring-mode CORDIC engine.
// It rotates (x, y) onto the positive x axis one micro-rotation per cycle.
// When it finishes, x holds K*|v| and z holds atan2(y, x) in Q3.29 radians.
// A single shift/add stage is reused for ITER cycles.
module cordic_vector_iter #(
    parameter int WIDTH = 32,
    parameter int ITER  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cordic_vector_iter_if.slave  bus
);
    // Two guard bits let -(-2^(WIDTH-1)) and the K*sqrt(2) growth fit.
    localparam int DW = WIDTH + 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_ITER = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [4:0]        LAST_STEP = 5'(ITER - 1);
    localparam logic signed [31:0] PI_Q29   = 32'sd1686629713;

    logic [1:0]           state;
    logic [4:0]           step;
    logic signed [DW-1:0] x;
    logic signed [DW-1:0] y;
    logic signed [31:0]   z;

    logic signed [DW-1:0] x_shift;
    logic signed [DW-1:0] y_shift;
    logic signed [DW-1:0] x_next;
    logic signed [DW-1:0] y_next;
    logic signed [31:0]   atan_step;
    logic signed [31:0]   z_next;

    // round(atan(2^-i) * 2^29) for i = 0..29
    function automatic logic signed [31:0] atan_rom(input logic [4:0] idx);
        case (idx)
            5'd0:    atan_rom = 32'sd421657428;
            5'd1:    atan_rom = 32'sd248918915;
            5'd2:    atan_rom = 32'sd131521918;
            5'd3:    atan_rom = 32'sd66762579;
            5'd4:    atan_rom = 32'sd33510843;
            5'd5:    atan_rom = 32'sd16771758;
            5'd6:    atan_rom = 32'sd8387925;
            5'd7:    atan_rom = 32'sd4194219;
            5'd8:    atan_rom = 32'sd2097141;
            5'd9:    atan_rom = 32'sd1048575;
            5'd10:   atan_rom = 32'sd524288;
            5'd11:   atan_rom = 32'sd262144;
            5'd12:   atan_rom = 32'sd131072;
            5'd13:   atan_rom = 32'sd65536;
            5'd14:   atan_rom = 32'sd32768;
            5'd15:   atan_rom = 32'sd16384;
            5'd16:   atan_rom = 32'sd8192;
            5'd17:   atan_rom = 32'sd4096;
            5'd18:   atan_rom = 32'sd2048;
            5'd19:   atan_rom = 32'sd1024;
            5'd20:   atan_rom = 32'sd512;
            5'd21:   atan_rom = 32'sd256;
            5'd22:   atan_rom = 32'sd128;
            5'd23:   atan_rom = 32'sd64;
            5'd24:   atan_rom = 32'sd32;
            5'd25:   atan_rom = 32'sd16;
            5'd26:   atan_rom = 32'sd8;
            5'd27:   atan_rom = 32'sd4;
            5'd28:   atan_rom = 32'sd2;
            5'd29:   atan_rom = 32'sd1;
            default: atan_rom = 32'sd0;
        endcase
    endfunction

    // One micro-rotation that drives y towards zero; y == 0 counts as non-negative.
    always_comb begin
        x_shift   = x >>> step;
        y_shift   = y >>> step;
        atan_step = atan_rom(step);
        if (!y[DW-1]) begin
            x_next = x + y_shift;
            y_next = y - x_shift;
            z_next = z + atan_step;
        end else begin
            x_next = x - y_shift;
            y_next = y + x_shift;
            z_next = z - atan_step;
        end
    end

    assign bus.in_ready = (state == ST_IDLE);

    // Sequencer: IDLE -> PRE -> ITER -> DONE -> IDLE, with the result registers held in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            step          <= '0;
            x             <= '0;
            y             <= '0;
            z             <= '0;
            bus.out_valid <= 1'b0;
            bus.mag_out   <= '0;
            bus.angle_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        x     <= {{2{bus.x_in[WIDTH-1]}}, bus.x_in};
                        y     <= {{2{bus.y_in[WIDTH-1]}}, bus.y_in};
                        state <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    // Fold the left half-plane into the right and preload +-pi.
                    // The sign of the original y selects +pi or -pi.
                    if (x[DW-1]) begin
                        x <= -x;
                        y <= -y;
                        z <= y[DW-1] ? -PI_Q29 : PI_Q29;
                    end else begin
                        z <= '0;
                    end
                    step  <= '0;
                    state <= ST_ITER;
                end
                ST_ITER: begin
                    x <= x_next;
                    y <= y_next;
                    z <= z_next;
                    if (step == LAST_STEP) begin
                        bus.out_valid <= 1'b1;
                        bus.mag_out   <= x_next;
                        bus.angle_out <= z_next;
                        state         <= ST_DONE;
                    end else begin
                        step <= step + 5'd1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_vector_iter.sv
// Directed bench for cordic_vector_iter (WIDTH=32, ITER=16).
// Small-vector expectations are bit-exact, traced by hand through the truncating shift/add
// recurrence. Full-scale vectors are compared against ideal K*|v| and atan2 with a tolerance.
module tb_cordic_vector_iter;
    localparam int WIDTH   = 32;
    localparam int ITER    = 16;
    localparam int LATENCY = ITER + 1;
    localparam int BOUND   = 100;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    cordic_vector_iter_if #(.WIDTH(WIDTH)) bus ();

    cordic_vector_iter #(.WIDTH(WIDTH), .ITER(ITER)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input longint observed,
                               input longint expected, input longint tol);
        longint diff;
        vectors++;
        diff = observed - expected;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (tol %0d)",
                     tag, observed, expected, tol);
        end
    endtask

    // Present one vector; it is accepted at the next rising edge.
    task automatic sendVector(input logic signed [31:0] xv, input logic signed [31:0] yv);
        @(negedge clk);
        checkOutput("in_ready before send", longint'(bus.in_ready), 1, 0);
        bus.in_valid = 1'b1;
        bus.x_in     = xv;
        bus.y_in     = yv;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Count rising edges after acceptance until out_valid appears, bounded.
    task automatic waitResult(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!bus.out_valid && cycles < BOUND);
    endtask

    task automatic applyStimulus(input string tag,
                                 input logic signed [31:0] xv, input logic signed [31:0] yv,
                                 input longint exp_mag, input longint exp_ang,
                                 input longint mag_tol, input longint ang_tol);
        int cyc;
        bus.out_ready = 1'b1;
        sendVector(xv, yv);
        waitResult(cyc);
        checkOutput({tag, " latency"}, longint'(cyc), LATENCY, 0);
        checkOutput({tag, " mag"}, longint'(bus.mag_out), exp_mag, mag_tol);
        checkOutput({tag, " angle"}, longint'(bus.angle_out), exp_ang, ang_tol);
        @(posedge clk);
        #1;
        checkOutput({tag, " valid drop"}, longint'(bus.out_valid), 0, 0);
        checkOutput({tag, " ready back"}, longint'(bus.in_ready), 1, 0);
    endtask

    initial begin
        int cyc;
        int highs;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset in_ready", longint'(bus.in_ready), 1, 0);
        checkOutput("reset out_valid", longint'(bus.out_valid), 0, 0);
        checkOutput("reset mag", longint'(bus.mag_out), 0, 0);
        checkOutput("reset angle", longint'(bus.angle_out), 0, 0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("x_axis",      1000,     0,  1649,  613145,      0, 0);
        applyStimulus("diag",        1000,  1000,  2335,  421501927,   0, 0);
        applyStimulus("neg_x",      -1000,     0,  1649,  1687242858,  0, 0);
        applyStimulus("neg_x_neg_y",-1000,    -1,  1654, -1685983800,  0, 0);
        applyStimulus("neg_y_axis",     0, -1000,  1649, -842701711,   0, 0);
        applyStimulus("full_scale", 32'sh8000_0000, 32'sh8000_0000,
                      64'sd5001211727, -1264972285, 64, 32768);
        applyStimulus("pos_y_axis", 0, 32'sh4000_0000,
                      1768195364, 843314857, 64, 32768);

        // Backpressure: result must hold while out_ready is low, new input ignored.
        bus.out_ready = 1'b0;
        sendVector(1000, 1000);
        waitResult(cyc);
        checkOutput("bp latency", longint'(cyc), LATENCY, 0);
        bus.in_valid = 1'b1;
        bus.x_in     = 7;
        bus.y_in     = 7;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            checkOutput("bp out_valid", longint'(bus.out_valid), 1, 0);
            checkOutput("bp in_ready", longint'(bus.in_ready), 0, 0);
            checkOutput("bp mag", longint'(bus.mag_out), 2335, 0);
            checkOutput("bp angle", longint'(bus.angle_out), 421501927, 0);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp accept valid", longint'(bus.out_valid), 0, 0);
        checkOutput("bp accept in_ready", longint'(bus.in_ready), 1, 0);
        highs = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) highs++;
        end
        checkOutput("bp no phantom result", longint'(highs), 0, 0);

        // Reset during the iterations: immediate clear, aborted vector never appears.
        sendVector(1000, 0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst out_valid", longint'(bus.out_valid), 0, 0);
        checkOutput("midrst mag", longint'(bus.mag_out), 0, 0);
        checkOutput("midrst angle", longint'(bus.angle_out), 0, 0);
        checkOutput("midrst in_ready", longint'(bus.in_ready), 1, 0);
        @(negedge clk);
        rst = 1'b0;
        highs = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) highs++;
        end
        checkOutput("midrst no result", longint'(highs), 0, 0);
        applyStimulus("after_reset", 3, 4, 9, 539334499, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
